// File: rtl/platform_recycler.sv
`default_nettype none
// ============================================================================
// platform_recycler : platform slot store with scroll-driven respawn scanner
// Revision 1.0
// ============================================================================
module platform_recycler #(
  parameter int unsigned SCREEN_WIDTH  = 400,
  parameter int unsigned SCREEN_HEIGHT = 700,
  parameter int unsigned BLOCK_WIDTH   = 40,
  parameter int unsigned BLOCK_HEIGHT  = 5,
  parameter int unsigned NUM_BLOCKS    = 8,
  parameter int unsigned SPAWN_GAP     = 90,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          new_view,
  input  logic [31:0]                   min_y,
  input  logic [$clog2(NUM_BLOCKS)-1:0] rd_idx,
  output logic [15:0]                   rd_x,
  output logic [31:0]                   rd_y,
  output logic                          busy,
  output logic                          scan_done,
  output logic [15:0]                   recycle_count
);

  localparam int unsigned        IDX_W     = $clog2(NUM_BLOCKS);
  localparam int unsigned        X_SPAN    = SCREEN_WIDTH - BLOCK_WIDTH + 1;
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_BLOCKS - 1);
  localparam logic [15:0]        LFSR_MASK = 16'hB400;

  // A single fold of the 9-bit LFSR sample must land inside the x range.
  if (2 * X_SPAN < 512 || NUM_BLOCKS < 2 || SPAWN_GAP >= SCREEN_HEIGHT ||
      LFSR_SEED == 16'd0) begin : g_badParams
    $error("platform_recycler: invalid parameter set");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [31:0]        r_slotY [NUM_BLOCKS];
  logic [15:0]        r_slotX [NUM_BLOCKS];
  logic [31:0]        r_highestY;
  logic [31:0]        r_minQ;
  logic [31:0]        r_pendingMin;
  logic               r_pending;
  logic [15:0]        r_lfsr;
  logic [IDX_W-1:0]   r_idx;
  logic               w_accept;
  logic               w_stale;
  logic               w_pendingSet;
  logic [8:0]         w_r;
  logic [8:0]         w_xr;
  logic [31:0]        w_spawnY;

  always_comb begin
    w_nextState  = r_state;
    w_accept     = 1'b0;
    w_stale      = 1'b0;
    // Anything arriving outside IDLE (including the DONE cycle) is deferred.
    w_pendingSet = new_view && (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (new_view || r_pending) begin
          w_accept    = 1'b1;
          w_nextState = SCAN;
        end
      end
      SCAN: begin
        w_stale = (r_slotY[r_idx] + 32'(BLOCK_HEIGHT)) <= r_minQ;
        if (r_idx == LAST_IDX) begin
          w_nextState = DONE;
        end
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  assign w_r       = r_lfsr[8:0];
  assign w_xr      = (w_r <= 9'(X_SPAN - 1)) ? w_r : w_r - 9'(X_SPAN);
  assign w_spawnY  = r_highestY + 32'(SPAWN_GAP);
  assign busy      = (r_state == SCAN);
  assign scan_done = (r_state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      for (int i = 0; i < int'(NUM_BLOCKS); i++) begin
        r_slotY[i] <= 32'(i * SPAWN_GAP);
        r_slotX[i] <= 16'((i * 47) % X_SPAN);
      end
      r_highestY    <= 32'((NUM_BLOCKS - 1) * SPAWN_GAP);
      r_minQ        <= 32'd0;
      r_pendingMin  <= 32'd0;
      r_pending     <= 1'b0;
      r_lfsr        <= LFSR_SEED;
      r_idx         <= '0;
      rd_x          <= 16'd0;
      rd_y          <= 32'd0;
      recycle_count <= 16'd0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_minQ <= new_view ? min_y : r_pendingMin;
        r_idx  <= '0;
      end else if (r_state == SCAN && r_idx != LAST_IDX) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_pendingSet) begin
        r_pending    <= 1'b1;
        r_pendingMin <= min_y;
      end else if (w_accept) begin
        r_pending <= 1'b0;
      end
      if (w_stale) begin
        r_slotY[r_idx] <= w_spawnY;
        r_slotX[r_idx] <= {7'd0, w_xr};
        r_highestY     <= w_spawnY;
        r_lfsr         <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_MASK : 16'd0);
        recycle_count  <= recycle_count + 16'd1;
      end
      // Reads see the slot contents from before this edge's write.
      rd_x <= r_slotX[rd_idx];
      rd_y <= r_slotY[rd_idx];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_platform_recycler.sv
`default_nettype none
// ============================================================================
// tb_platform_recycler : directed bench with a whole-scan reference model
// Revision 1.0
// ============================================================================
module tb_platform_recycler;

  localparam int N     = 8;
  localparam int GAP   = 90;
  localparam int XSPAN = 361;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_view;
  logic [31:0] min_y;
  logic [2:0]  rd_idx;
  logic [15:0] rd_x;
  logic [31:0] rd_y;
  logic        busy;
  logic        scan_done;
  logic [15:0] recycle_count;

  int total = 0;
  int bad   = 0;

  platform_recycler dut (
    .clk          (clk),
    .reset        (reset),
    .new_view     (new_view),
    .min_y        (min_y),
    .rd_idx       (rd_idx),
    .rd_x         (rd_x),
    .rd_y         (rd_y),
    .busy         (busy),
    .scan_done    (scan_done),
    .recycle_count(recycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: a whole scan is resolved at acceptance; per-cycle
  // visibility is then derived from the edge offset since acceptance.
  logic [31:0] curY [N];
  logic [31:0] nxtY [N];
  logic [15:0] curX [N];
  logic [15:0] nxtX [N];
  bit          stale [N];
  logic [31:0] mHigh;
  logic [31:0] pendMin;
  logic [15:0] mLfsr;
  logic [15:0] curCnt;
  bit          pend;
  bit          mValid = 1'b0;
  int          cyc = 0;
  int          lastAcc = -1000;
  int          jOff;
  int          ri;
  logic [15:0] eX;
  logic [31:0] eY;
  logic [15:0] eCnt;
  bit          eBusy;
  bit          eDone;

  function automatic logic [15:0] lfsrNext(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] xOf(input logic [15:0] l);
    int r;
    r = int'(l) % 512;
    return 16'((r > XSPAN - 1) ? r - XSPAN : r);
  endfunction

  function automatic void startScan(input logic [31:0] m);
    for (int k = 0; k < N; k++) begin
      if (stale[k]) curCnt = curCnt + 16'd1;
      curY[k] = nxtY[k];
      curX[k] = nxtX[k];
    end
    for (int k = 0; k < N; k++) begin
      stale[k] = (curY[k] + 32'd5) <= m;
      if (stale[k]) begin
        mHigh   = mHigh + 32'(GAP);
        nxtY[k] = mHigh;
        nxtX[k] = xOf(mLfsr);
        mLfsr   = lfsrNext(mLfsr);
      end else begin
        nxtY[k] = curY[k];
        nxtX[k] = curX[k];
      end
    end
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        curY[k]  = 32'(k * GAP);
        curX[k]  = 16'((k * 47) % XSPAN);
        nxtY[k]  = curY[k];
        nxtX[k]  = curX[k];
        stale[k] = 1'b0;
      end
      mHigh   = 32'((N - 1) * GAP);
      mLfsr   = 16'hACE1;
      curCnt  = 16'd0;
      pend    = 1'b0;
      lastAcc = cyc - 1000;
      eX = 16'd0; eY = 32'd0; eCnt = 16'd0; eBusy = 1'b0; eDone = 1'b0;
      mValid  = 1'b1;
    end else begin
      if ((cyc - lastAcc >= N + 2) && (new_view || pend)) begin
        startScan(new_view ? min_y : pendMin);
        lastAcc = cyc;
        pend    = 1'b0;
      end else if (new_view) begin
        pend    = 1'b1;
        pendMin = min_y;
      end
      jOff = cyc - lastAcc;
      ri   = int'(rd_idx);
      eX   = (ri + 1 < jOff) ? nxtX[ri] : curX[ri];
      eY   = (ri + 1 < jOff) ? nxtY[ri] : curY[ri];
      eCnt = curCnt;
      for (int k = 0; k < N; k++)
        if (stale[k] && k + 1 <= jOff) eCnt = eCnt + 16'd1;
      eBusy = (jOff >= 0) && (jOff <= N - 1);
      eDone = (jOff == N);
    end
  end

  always @(negedge clk) begin
    if (mValid) begin
      chk("busy", busy, eBusy);
      chk("scan_done", scan_done, eDone);
      chk("recycle_count", recycle_count, eCnt);
      chk("rd_x", rd_x, eX);
      chk("rd_y", rd_y, eY);
      chk("rd_x range", rd_x <= 16'd360, 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic scroll(input logic [31:0] m);
    new_view = 1'b1;
    min_y    = m;
    tick();
    new_view = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic waitDone(output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      rd_idx = rd_idx + 3'd1;
      tick();
      if (scan_done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic readSlot(input int idx, output logic [15:0] x, output logic [31:0] y);
    rd_idx = 3'(idx);
    tick();
    x = rd_x;
    y = rd_y;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [15:0] x;
    logic [31:0] y;
    int n;
    int n2;
    int extra;
    int q[$];

    reset = 1'b1; new_view = 1'b0; min_y = 32'd0; rd_idx = 3'd0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset contents
    readSlot(3, x, y);
    chk("reset slot3 x", x, 141);
    chk("reset slot3 y", y, 270);
    chk("reset busy", busy, 0);
    chk("reset count", recycle_count, 0);

    // Basic respawn
    scroll(32'd100);
    waitDone(n);
    chk("done latency", n, 8);
    readSlot(0, x, y);
    chk("slot0 y", y, 720);
    chk("slot0 x", x, 225);
    readSlot(1, x, y);
    chk("slot1 y", y, 810);
    chk("slot1 x", x, 112);
    readSlot(2, x, y);
    chk("slot2 y", y, 180);
    chk("count after 100", recycle_count, 2);

    // Stale boundary
    doReset();
    scroll(32'd94);
    waitDone(n);
    readSlot(1, x, y);
    chk("min94 slot1 y", y, 90);
    chk("min94 count", recycle_count, 1);
    doReset();
    scroll(32'd95);
    waitDone(n);
    readSlot(1, x, y);
    chk("min95 slot1 y", y, 810);

    // Coalescing: 200 then 300 arrive mid-scan, only 300 is scanned
    doReset();
    scroll(32'd100);
    tick();
    scroll(32'd200);
    tick();
    scroll(32'd300);
    waitDone(n);
    n2 = -1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (busy) begin
        n2 = i;
        break;
      end
    end
    chk("rescan start edge", 4 + n + n2, N + 2);
    waitDone(n);
    chk("second scan done", n >= 0, 1);
    extra = 0;
    repeat (20) begin
      tick();
      if (scan_done) extra++;
    end
    chk("no third scan", extra, 0);
    readSlot(3, x, y);
    chk("coalesced slot3 y", y, 990);
    chk("coalesced slot3 x", x, 156);
    chk("coalesced count", recycle_count, 4);

    // Reset in the middle of a scan
    doReset();
    scroll(32'd100);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset busy", busy, 0);
    chk("midreset count", recycle_count, 0);
    readSlot(0, x, y);
    chk("midreset slot0 y", y, 0);
    chk("midreset slot0 x", x, 0);
    readSlot(1, x, y);
    chk("midreset slot1 y", y, 90);
    chk("midreset slot1 x", x, 47);
    extra = 0;
    repeat (15) begin
      tick();
      if (scan_done) extra++;
    end
    chk("midreset no done", extra, 0);
    scroll(32'd100);
    waitDone(n);
    readSlot(0, x, y);
    chk("midreset lfsr restart x", x, 225);

    // Long sweep
    doReset();
    for (int s = 1; s <= 200; s++) begin
      scroll(32'(s * GAP));
      waitDone(n);
      chk("sweep scan latency", n, 8);
      tick();
    end
    for (int i = 0; i < N; i++) begin
      readSlot(i, x, y);
      q.push_back(int'(y));
    end
    q.sort();
    for (int i = 0; i < N - 1; i++)
      chk("sweep y spacing", q[i + 1] - q[i], GAP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
